// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - Request/response bundle between the execute stage and div_unit
//
// Purpose: groups the divider handshake so the pipeline and the unit share one port.
// Signals:
//   start  - request, qualified by flush and the unit's state
//   flush  - synchronous abort from the pipeline
//   a, b   - dividend (rs1) and divisor (rs2)
//   fn3    - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   busy   - unit is iterating (CALC or FIX)
//   done   - one-cycle completion pulse
//   result - quotient or remainder, held until the next completion
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [1:0]      fn3;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, a, b, fn3,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, a, b, fn3,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - Iterative RV32M radix-2 restoring divide/remainder unit
//
// Purpose: runs DIV/DIVU/REM/REMU over 32 iterations (plus a sign-fix cycle);
//          divide-by-zero and signed overflow complete in one cycle.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high reset
//   bus - div_unit_if slave: start/flush/a/b/fn3 in, busy/done/result out
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            sel_rem_q, sel_rem_d;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            sgn_ovf;
  logic            accept;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic            borrow;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Operand decode, evaluated on the raw inputs in the accept cycle.
  assign is_signed = ~bus.fn3[0];
  assign a_neg     = is_signed & bus.a[XLEN-1];
  assign b_neg     = is_signed & bus.b[XLEN-1];
  assign b_zero    = (bus.b == '0);
  assign sgn_ovf   = is_signed & (bus.a == INT_MIN) & (bus.b == '1);
  assign a_mag     = a_neg ? (-bus.a) : bus.a;
  assign b_mag     = b_neg ? (-bus.b) : bus.b;
  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && bus.start && !bus.flush;

  // quo_q starts out holding the dividend magnitude: each shift moves its MSB
  // into the partial remainder and frees the LSB for the new quotient bit.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dvsr_q};
  // rem_q < dvsr_q always holds, so rem_sh < 2*dvsr_q. A successful subtract
  // then leaves a value below dvsr_q (bit XLEN clear); a failed one wraps to
  // at least 2^(XLEN+1) - dvsr_q, which always has bit XLEN set.
  assign borrow = trial[XLEN];

  assign quo_fix = neg_quo_q ? (-quo_q) : quo_q;
  assign rem_fix = neg_rem_q ? (-rem_q) : rem_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (b_zero) begin
            result_d = bus.fn3[1] ? bus.a : '1;
            state_d  = DONE;
          end else if (sgn_ovf) begin
            result_d = bus.fn3[1] ? '0 : INT_MIN;
            state_d  = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = a_mag;
            dvsr_d    = b_mag;
            cnt_d     = 5'd0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            sel_rem_d = bus.fn3[1];
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = borrow ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ~borrow};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = sel_rem_q ? rem_fix : quo_fix;
        state_d  = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An aborted operation must leave the previously delivered result intact.
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  assign bus.busy   = (state_q == CALC) || (state_q == FIX);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - Self-checking bench for div_unit
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last  = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn);
    return (b == 32'h0) || (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RV32M semantics straight from arithmetic on wide signed/unsigned integers.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn);
    longint sa;
    longint sb;
    if (b == 32'h0) return fn[1] ? a : 32'hFFFF_FFFF;
    if (!fn[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return fn[1] ? 32'h0 : 32'h8000_0000;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return fn[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return fn[1] ? (a % b) : (a / b);
  endfunction

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'h0);
  endtask

  // Issues one op with start in the current cycle and leaves the bench in its done cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn, input string tag);
    int          lat;
    bit          busy_ok;
    logic [31:0] expv;
    expv      = ref_model(a, b, fn);
    bus.a     = a;
    bus.b     = b;
    bus.fn3   = fn;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.fn3   = 2'($urandom);
    lat       = 1;
    busy_ok   = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), is_special(a, b, fn) ? 32'd1 : 32'd34);
    check({tag, "_busy_calc"}, 32'(busy_ok), 32'h1);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'h0);
    check({tag, "_result"}, bus.result, expv);
    last = expv;
  endtask

  initial begin
    int          lat;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rf;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.fn3   = '0;
    tick();
    tick();
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_result", bus.result, 32'h0);
    rst = 1'b0;
    tick();

    // Directed ops.
    do_op(32'd100, 32'd7, 2'b01, "divu_100_7");
    tick();
    check("done_single_pulse", 32'(bus.done), 32'h0);
    do_op(32'd100, 32'd7, 2'b11, "remu_100_7");
    tick();
    do_op(32'hFFFF_FFF9, 32'd2, 2'b10, "rem_m7_2");
    tick();
    do_op(32'hFFFF_FFF9, 32'd2, 2'b00, "div_m7_2");
    tick();
    do_op(32'h1234_5678, 32'h0, 2'b00, "div_by_zero");
    tick();
    do_op(32'h1234_5678, 32'h0, 2'b11, "remu_by_zero");
    tick();
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, "div_ovf");
    tick();
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, "rem_ovf");
    tick();
    do_op(32'hFFFF_FFFF, 32'h8000_0001, 2'b11, "remu_big_divisor");
    tick();

    // Start during CALC is ignored.
    bus.a     = 32'd1000;
    bus.b     = 32'd10;
    bus.fn3   = 2'b01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.a     = 32'd7;
    bus.b     = 32'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(6, lat);
    check("ignored_start_latency", 32'(lat), 32'd34);
    check("ignored_start_result", bus.result, 32'd100);

    // Back-to-back from the DONE cycle, then two special cases back-to-back.
    do_op(32'd9, 32'd3, 2'b01, "b2b_divu_9_3");
    do_op(32'd5, 32'd0, 2'b01, "b2b_special_a");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, "b2b_special_b");
    tick();
    check("b2b_done_drop", 32'(bus.done), 32'h0);

    // Flush mid-calculation.
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    bus.fn3   = 2'b00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'h0);
    check("flush_done", 32'(bus.done), 32'h0);
    check("flush_result_kept", bus.result, last);
    watch_no_done("flush_no_done", 40);

    // Asynchronous reset mid-calculation.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    check("arst_result", bus.result, 32'h0);
    tick();
    rst  = 1'b0;
    last = 32'h0;
    watch_no_done("arst_no_done", 40);

    // Flush together with start: nothing accepted.
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h0;
    bus.fn3   = 2'b11;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'h0);
    check("flush_start_done", 32'(bus.done), 32'h0);
    check("flush_start_result", bus.result, 32'h0);
    watch_no_done("flush_start_no_done", 40);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rf = 2'($urandom);
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      do_op(ra, rb, rf, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check($sformatf("rand%0d_done_drop", i), 32'(bus.done), 32'h0);
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide/remainder unit that sits beside the single-cycle ALU in the execute stage. It takes the same operand pair and `fn3` encoding from decode, and runs DIV, DIVU, REM and REMU with a radix-2 restoring algorithm over 32 iterations. Divide-by-zero and signed overflow bypass the loop and complete in one cycle. The pipeline stalls on `busy` and captures `result` on the `done` pulse.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only when the unit is idle or in the done cycle.
- `flush`  in  1  synchronous abort from pipeline flush; has priority over `start`.
- `a`  in  32  dividend (rs1); sampled with `start`.
- `b`  in  32  divisor (rs2); sampled with `start`.
- `fn3`  in  2  low bits of funct3: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`.
- `busy`  out  1  high while an operation is iterating.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  quotient or remainder; held until the next accepted operation completes.

## Operation
- State machine: IDLE, CALC, FIX, DONE. DONE lasts one cycle, then returns to IDLE unless a new `start` is accepted in that cycle.
- Accept rule: `start` is accepted when state is IDLE or DONE and `flush`=0. `start` during CALC/FIX is ignored and produces no side effect.
- Signed ops (DIV, REM): operands are converted to magnitudes. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Unsigned ops: operands are used as-is.
- Special cases are decided at accept time, from the raw operands. They go straight to DONE.
  - b == 0: quotient = 0xFFFFFFFF and remainder = a, for both signed and unsigned ops.
  - Signed and a == 0x80000000 and b == 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC, one iteration per cycle, 5-bit counter 0..31:
  - Shift {rem, quo} left by 1, shifting in the next dividend MSB.
  - Trial subtract: rem − |b|, computed 33 bits wide.
  - If no borrow: rem = difference and quotient bit = 1. Otherwise rem is kept and quotient bit = 0.
- FIX: apply two's-complement negation per the sign rules above. Select quotient (fn3[1]=0) or remainder (fn3[1]=1), register it into `result`, then go to DONE.
- `flush`: from any state, the next state is IDLE. `done` is not asserted, `result` keeps its previous value, and the pending `start` is dropped.
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, all internal registers 0.

## Timing
- Normal op, with `start` accepted in cycle N:
  - Operands latched at the end of cycle N.
  - CALC in cycles N+1..N+32.
  - FIX in cycle N+33.
  - `done`=1 and `result` valid in cycle N+34.
- Special case, with `start` accepted in cycle N: `done`=1 and `result` valid in cycle N+1. `busy` is never asserted.
- `busy` = 1 exactly in CALC and FIX (cycles N+1..N+33). It is 0 in the DONE cycle.
- Back-to-back: a `start` in the DONE cycle is accepted. The next operation's CALC begins the following cycle with no idle bubble.
- `done` never stays high for two consecutive cycles from one operation. Two special-case ops back-to-back give `done` in consecutive cycles, each with its own `result`.
- Operand inputs may change freely after the accept cycle; only the latched copies are used.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronous). After deassertion the unit is IDLE and no `done` appears for the aborted operation.

## Test plan
- DIVU a=100, b=7, start in cycle N -> `busy` high N+1..N+33; `done` with `result`=14 in N+34. Repeat with REMU -> `result`=2.
- REM a=0xFFFFFFF9 (−7), b=2 -> `result`=0xFFFFFFFF (−1). DIV with the same operands -> `result`=0xFFFFFFFD (−3).
- DIV a=0x12345678, b=0 -> `done` in N+1 with `result`=0xFFFFFFFF and `busy` never high. REMU with the same operands -> `result`=0x12345678.
- DIV a=0x80000000, b=0xFFFFFFFF -> `result`=0x80000000 in N+1. REM with the same operands -> `result`=0.
- Start DIVU 1000/10:
  - Pulse `start` with different operands in cycle N+5 -> ignored; `result`=100 in N+34.
  - Issue DIVU 9/3 in the DONE cycle -> `result`=3 exactly 34 cycles later.
- Start DIV 50/5:
  - Assert `flush` in N+10 -> no `done`, IDLE in N+11, `result` unchanged.
  - Separately, assert `rst` in N+20 -> `busy`=0, `done`=0, `result`=0 immediately.
  - Assert `flush` together with `start` -> nothing is accepted.
